// File: rtl/dmem_port_arbiter.sv
// Shares the data memory between the MEM stage (priority) and an external port;
// EXT gets a one-cycle grant, ack one cycle later, forced after STARVE_LIMIT lost cycles.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             ext_win;

  // The counter saturates at LIMIT, so equality is the same as ">=" here.
  assign ext_win   = (state == IDLE) && ext_req && (!cpu_req || (starve_cnt == LIMIT));
  assign cpu_rdata = mem_rdata;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    cpu_stall = 1'b0;
    if (ext_win) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_we    = ext_we;
      mem_re    = !ext_we;
      cpu_stall = cpu_req;
    end else if (cpu_req) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
      mem_re    = !cpu_we;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      ext_ack    <= 1'b0;
      ext_rdata  <= '0;
    end else if (state == IDLE) begin
      if (ext_win) begin
        state     <= ACK;
        ext_ack   <= 1'b1;
        ext_rdata <= mem_rdata;
      end else if (ext_req && cpu_req && (starve_cnt != LIMIT)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end else begin
      // ACK cycle: the CPU is served combinationally; EXT cannot win again until IDLE.
      state      <= IDLE;
      ext_ack    <= 1'b0;
      starve_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench: stimulus queues per-cycle and per-ack expectations, monitors compare.
module tb_dmem_port_arbiter;

  logic        Clk, Reset;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;

  logic [31:0] cpu_rdata0, ext_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
  logic        cpu_stall0, ext_ack0, mem_we0, mem_re0;
  logic [31:0] cpu_rdata1, ext_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        cpu_stall1, ext_ack1, mem_we1, mem_re1;

  typedef struct {
    string       name;
    bit          chk_mem;
    bit          stall;
    bit          we;
    bit          re;
    logic [31:0] addr;
    bit          ack;
    bit          chk_rd;
    logic [31:0] rd;
  } exp_t;

  exp_t        cyc0_q[$];
  exp_t        cyc1_q[$];
  logic [31:0] ack0_q[$];
  logic [31:0] mem [0:15];
  int          checks = 0;
  int          errors = 0;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(8), .CNT_W(4)) u_dut0 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata0), .cpu_stall(cpu_stall0),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ack(ext_ack0), .ext_rdata(ext_rdata0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_we(mem_we0), .mem_re(mem_re0),
    .mem_rdata(mem_rdata0)
  );

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(0), .CNT_W(4)) u_dut1 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata1), .cpu_stall(cpu_stall1),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ack(ext_ack1), .ext_rdata(ext_rdata1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1), .mem_re(mem_re1),
    .mem_rdata(mem_rdata1)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Memory model for the STARVE_LIMIT=8 instance: async read gated by re, sync write.
  assign mem_rdata0 = mem_re0 ? mem[mem_addr0[5:2]] : 32'h0;
  assign mem_rdata1 = mem_addr1 ^ 32'h5A5A_5A5A;
  always @(posedge Clk) if (mem_we0) mem[mem_addr0[5:2]] <= mem_wdata0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, act, exp, $time);
    end
  endtask

  task automatic cmp(exp_t e, logic st, logic we, logic re, logic [31:0] a, logic ak,
                     logic [31:0] rd);
    chk({e.name, ".stall"}, 32'(st), 32'(e.stall));
    chk({e.name, ".ack"}, 32'(ak), 32'(e.ack));
    if (e.chk_mem) begin
      chk({e.name, ".mem_we"}, 32'(we), 32'(e.we));
      chk({e.name, ".mem_re"}, 32'(re), 32'(e.re));
      chk({e.name, ".mem_addr"}, a, e.addr);
    end
    if (e.chk_rd) chk({e.name, ".ext_rdata"}, rd, e.rd);
  endtask

  always @(negedge Clk) begin
    if (cyc0_q.size() > 0)
      cmp(cyc0_q.pop_front(), cpu_stall0, mem_we0, mem_re0, mem_addr0, ext_ack0, ext_rdata0);
    if (ext_ack0 === 1'b1) begin
      if (ack0_q.size() == 0) chk("unexpected_ack", 32'(ext_ack0), 32'h0);
      else chk("ack_rdata", ext_rdata0, ack0_q.pop_front());
    end
  end

  always @(negedge Clk) begin
    if (cyc1_q.size() > 0)
      cmp(cyc1_q.pop_front(), cpu_stall1, mem_we1, mem_re1, mem_addr1, ext_ack1, ext_rdata1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drv(bit cr, bit cw, logic [31:0] ca, logic [31:0] cd,
                     bit er, bit ew, logic [31:0] ea, logic [31:0] ed);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed;
  endtask

  function automatic exp_t mk(string n, bit cm, bit st, bit we, bit re, logic [31:0] a,
                              bit ak, bit cr, logic [31:0] rd);
    exp_t e;
    e.name = n; e.chk_mem = cm; e.stall = st; e.we = we; e.re = re;
    e.addr = a; e.ack = ak; e.chk_rd = cr; e.rd = rd;
    return e;
  endfunction

  task automatic idle(string n);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    cyc0_q.push_back(mk(n, 1, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // Contended CPU read of 0x20 vs EXT write to 0x30: 8 CPU wins, forced EXT, then ACK.
  task automatic starve_run(string tag);
    for (int i = 0; i < 8; i++) begin
      tick();
      drv(1, 0, 32'h20, 0, 1, 1, 32'h30, 32'h1234);
      cyc0_q.push_back(mk({tag, "_cpu"}, 1, 0, 0, 1, 32'h20, 0, 0, 0));
    end
    tick();
    drv(1, 0, 32'h20, 0, 1, 1, 32'h30, 32'h1234);
    cyc0_q.push_back(mk({tag, "_forced"}, 1, 1, 1, 0, 32'h30, 0, 0, 0));
    tick();
    drv(1, 0, 32'h20, 0, 0, 0, 0, 0);
    cyc0_q.push_back(mk({tag, "_ackcyc"}, 1, 0, 0, 1, 32'h20, 1, 0, 0));
    ack0_q.push_back(32'h0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    Reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      tick();
      drv(1'($urandom), 1'($urandom), $urandom, $urandom,
          1'($urandom), 1'($urandom), $urandom, $urandom);
      cyc0_q.push_back(mk("in_reset", 0, 0, 0, 0, 0, 0, 1, 32'h0));
    end
    tick();
    Reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    cyc0_q.push_back(mk("post_reset_idle", 1, 0, 0, 0, 0, 0, 0, 0));

    // EXT write then read with the CPU idle
    tick();
    drv(0, 0, 0, 0, 1, 1, 32'h10, 32'hDEAD_BEEF);
    cyc0_q.push_back(mk("ext_wr", 1, 0, 1, 0, 32'h10, 0, 0, 0));
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    cyc0_q.push_back(mk("ext_wr_ack", 1, 0, 0, 0, 0, 1, 0, 0));
    ack0_q.push_back(32'h0);
    tick();
    drv(0, 0, 0, 0, 1, 0, 32'h10, 0);
    cyc0_q.push_back(mk("ext_rd", 1, 0, 0, 1, 32'h10, 0, 0, 0));
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    cyc0_q.push_back(mk("ext_rd_ack", 1, 0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF));
    ack0_q.push_back(32'hDEAD_BEEF);

    // Starvation: two back-to-back runs show the counter cleared by the ACK cycle
    starve_run("starve1");
    starve_run("starve2");
    idle("after_starve");

    // Same contention on both instances: limit 8 keeps the CPU, limit 0 hands to EXT
    tick();
    drv(1, 1, 32'h40, 32'h77, 1, 0, 32'h10, 0);
    cyc0_q.push_back(mk("l8_contend", 1, 0, 1, 0, 32'h40, 0, 0, 0));
    cyc1_q.push_back(mk("l0_contend", 1, 1, 0, 1, 32'h10, 0, 0, 0));
    tick();
    drv(1, 1, 32'h40, 32'h77, 0, 0, 0, 0);
    cyc0_q.push_back(mk("l8_cpu_again", 1, 0, 1, 0, 32'h40, 0, 0, 0));
    cyc1_q.push_back(mk("l0_ack_cpu", 1, 0, 1, 0, 32'h40, 1, 0, 0));
    idle("after_l0");

    // EXT held high: one grant every other cycle
    for (int i = 0; i < 6; i++) begin
      tick();
      drv(0, 0, 0, 0, 1, 0, 32'h10, 0);
      if (i % 2 == 0) begin
        cyc0_q.push_back(mk("burst_grant", 1, 0, 0, 1, 32'h10, 0, 0, 0));
      end else begin
        cyc0_q.push_back(mk("burst_ack", 1, 0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF));
        ack0_q.push_back(32'hDEAD_BEEF);
      end
    end
    idle("after_burst");

    // Reset asserted during the ACK cycle
    tick();
    drv(0, 0, 0, 0, 1, 0, 32'h10, 0);
    cyc0_q.push_back(mk("pre_rst_grant", 1, 0, 0, 1, 32'h10, 0, 0, 0));
    tick();
    Reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    cyc0_q.push_back(mk("rst_in_ack", 1, 0, 0, 0, 0, 0, 1, 32'h0));
    tick();
    Reset = 1'b1;
    drv(0, 0, 0, 0, 1, 0, 32'h10, 0);
    cyc0_q.push_back(mk("post_rst_grant", 1, 0, 0, 1, 32'h10, 0, 0, 0));
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    cyc0_q.push_back(mk("post_rst_ack", 1, 0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF));
    ack0_q.push_back(32'hDEAD_BEEF);
    idle("final_idle");

    repeat (3) tick();
    chk("ack_q_drained", 32'(ack0_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
